mips_load_align_wb: RTL and testbench

//  Multi-cycle load write-back stage feeding the MIPS register file (posedge-registered outputs; the register file writes on negedge).

---
 rtl/mips_load_align_wb.sv | 210 +++++++++++++++++++++
 tb/tb_mips_load_align_wb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_load_align_wb.sv
// Load write-back stage: memory read, lane alignment, extension, reg-file write.
// Define UNALIGNED_LOAD_EN to enable the LWL/LWR merge path.
module mips_load_align_wb #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_valid,
    output logic        Req_ready,
    input  logic [2:0]  Req_op,
    input  logic [1:0]  Req_addr_lo,
    input  logic [4:0]  Req_dest,
    output logic        Mem_req,
    input  logic        Mem_rvalid,
    input  logic [31:0] Mem_rdata,
    output logic [4:0]  Rd_addr,
    output logic [31:0] Rd_in,
    output logic [3:0]  Rd_write_byte_en,
    output logic        Done,
    output logic        Addr_err,
    output logic        Timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LWL = 3'b010;
    localparam logic [2:0] OP_LW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LWR = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [2:0]    op_q, op_n;
    logic [1:0]    k_q, k_n;
    logic [4:0]    dest_q, dest_n;

    logic        mem_req_n;
    logic [4:0]  rd_addr_n;
    logic [31:0] rd_in_n;
    logic [3:0]  en_n;
    logic        done_n;
    logic        aerr_n;
    logic        tmo_n;

    logic        req_legal;
    logic [31:0] byte_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] align_data;
    logic [3:0]  align_en;

    assign Req_ready = (state_q == IDLE) & ~Reset;

    always_comb begin
        req_legal = 1'b1;
        case (Req_op)
            OP_LB, OP_LBU: req_legal = 1'b1;
            OP_LH, OP_LHU: req_legal = ~Req_addr_lo[0];
            OP_LW:         req_legal = (Req_addr_lo == 2'b00);
`ifdef UNALIGNED_LOAD_EN
            OP_LWL, OP_LWR: req_legal = 1'b1;
`else
            OP_LWL, OP_LWR: req_legal = 1'b0;
`endif
            default:       req_legal = 1'b0;
        endcase
    end

    assign byte_sh = Mem_rdata >> {k_q, 3'b000};
    assign lane_b  = byte_sh[7:0];
    assign lane_h  = k_q[1] ? Mem_rdata[31:16] : Mem_rdata[15:0];

    always_comb begin
        align_data = 32'h0;
        align_en   = 4'b0000;
        case (op_q)
            OP_LB: begin
                align_data = {{24{lane_b[7]}}, lane_b};
                align_en   = 4'b1111;
            end
            OP_LBU: begin
                align_data = {24'h0, lane_b};
                align_en   = 4'b1111;
            end
            OP_LH: begin
                align_data = {{16{lane_h[15]}}, lane_h};
                align_en   = 4'b1111;
            end
            OP_LHU: begin
                align_data = {16'h0, lane_h};
                align_en   = 4'b1111;
            end
            OP_LW: begin
                align_data = Mem_rdata;
                align_en   = 4'b1111;
            end
`ifdef UNALIGNED_LOAD_EN
            // 3-k equals ~k for a 2-bit lane index
            OP_LWL: begin
                align_data = Mem_rdata << {~k_q, 3'b000};
                align_en   = 4'b1111 << ~k_q;
            end
            OP_LWR: begin
                align_data = Mem_rdata >> {k_q, 3'b000};
                align_en   = 4'b1111 >> k_q;
            end
`endif
            default: begin
                align_data = 32'h0;
                align_en   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        op_n      = op_q;
        k_n       = k_q;
        dest_n    = dest_q;
        mem_req_n = 1'b0;
        rd_addr_n = 5'd0;
        rd_in_n   = 32'h0;
        en_n      = 4'b0000;
        done_n    = 1'b0;
        aerr_n    = 1'b0;
        tmo_n     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req_valid) begin
                    if (req_legal) begin
                        state_n   = WAIT_MEM;
                        cnt_n     = '0;
                        op_n      = Req_op;
                        k_n       = Req_addr_lo;
                        dest_n    = Req_dest;
                        mem_req_n = 1'b1;
                    end else begin
                        aerr_n = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // a response in the last counted cycle still completes the load
                if (Mem_rvalid) begin
                    state_n   = WRITE;
                    cnt_n     = '0;
                    done_n    = 1'b1;
                    rd_addr_n = dest_q;
                    rd_in_n   = align_data;
                    en_n      = align_en;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    tmo_n   = 1'b1;
                end else begin
                    cnt_n     = cnt_q + CW'(1);
                    mem_req_n = 1'b1;
                end
            end
            WRITE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            op_q             <= 3'b000;
            k_q              <= 2'b00;
            dest_q           <= 5'd0;
            Mem_req          <= 1'b0;
            Rd_addr          <= 5'd0;
            Rd_in            <= 32'h0;
            Rd_write_byte_en <= 4'b0000;
            Done             <= 1'b0;
            Addr_err         <= 1'b0;
            Timeout          <= 1'b0;
        end else begin
            state_q          <= state_n;
            cnt_q            <= cnt_n;
            op_q             <= op_n;
            k_q              <= k_n;
            dest_q           <= dest_n;
            Mem_req          <= mem_req_n;
            Rd_addr          <= rd_addr_n;
            Rd_in            <= rd_in_n;
            Rd_write_byte_en <= en_n;
            Done             <= done_n;
            Addr_err         <= aerr_n;
            Timeout          <= tmo_n;
        end
    end

endmodule

// File: tb/tb_mips_load_align_wb.sv
// Directed bench for mips_load_align_wb: alignment vectors, illegal ops,
// timeout boundary and reset abort.
module tb_mips_load_align_wb;

    logic        Clk;
    logic        Reset;
    logic        Req_valid;
    logic        Req_ready;
    logic [2:0]  Req_op;
    logic [1:0]  Req_addr_lo;
    logic [4:0]  Req_dest;
    logic        Mem_req;
    logic        Mem_rvalid;
    logic [31:0] Mem_rdata;
    logic [4:0]  Rd_addr;
    logic [31:0] Rd_in;
    logic [3:0]  Rd_write_byte_en;
    logic        Done;
    logic        Addr_err;
    logic        Timeout;

    int checks = 0;
    int errors = 0;

    mips_load_align_wb #(.TIMEOUT_CYCLES(16)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Req_valid(Req_valid),
        .Req_ready(Req_ready),
        .Req_op(Req_op),
        .Req_addr_lo(Req_addr_lo),
        .Req_dest(Req_dest),
        .Mem_req(Mem_req),
        .Mem_rvalid(Mem_rvalid),
        .Mem_rdata(Mem_rdata),
        .Rd_addr(Rd_addr),
        .Rd_in(Rd_in),
        .Rd_write_byte_en(Rd_write_byte_en),
        .Done(Done),
        .Addr_err(Addr_err),
        .Timeout(Timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_load(input string tag, input logic [2:0] op,
                            input logic [1:0] k, input logic [4:0] dest,
                            input logic [31:0] data,
                            input logic [31:0] exp_in,
                            input logic [3:0] exp_en);
        Req_valid = 1'b1;
        Req_op = op;
        Req_addr_lo = k;
        Req_dest = dest;
        step();
        Req_valid = 1'b0;
        chk({tag, "_memreq"}, 32'(Mem_req), 32'd1);
        chk({tag, "_busy"}, 32'(Req_ready), 32'd0);
        Mem_rvalid = 1'b1;
        Mem_rdata = data;
        step();
        Mem_rvalid = 1'b0;
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_addr"}, 32'(Rd_addr), 32'(dest));
        chk({tag, "_data"}, Rd_in, exp_in);
        chk({tag, "_en"}, 32'(Rd_write_byte_en), 32'(exp_en));
        step();
        chk({tag, "_done_off"}, 32'(Done), 32'd0);
        chk({tag, "_en_off"}, 32'(Rd_write_byte_en), 32'd0);
        chk({tag, "_addr_off"}, 32'(Rd_addr), 32'd0);
        chk({tag, "_ready"}, 32'(Req_ready), 32'd1);
    endtask

    task automatic run_illegal(input string tag, input logic [2:0] op,
                               input logic [1:0] k);
        Req_valid = 1'b1;
        Req_op = op;
        Req_addr_lo = k;
        Req_dest = 5'd9;
        step();
        Req_valid = 1'b0;
        chk({tag, "_aerr"}, 32'(Addr_err), 32'd1);
        chk({tag, "_memreq"}, 32'(Mem_req), 32'd0);
        chk({tag, "_en"}, 32'(Rd_write_byte_en), 32'd0);
        chk({tag, "_ready"}, 32'(Req_ready), 32'd1);
        step();
        chk({tag, "_aerr_off"}, 32'(Addr_err), 32'd0);
        chk({tag, "_memreq2"}, 32'(Mem_req), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
    endtask

    initial begin
        logic all_req;
        Reset = 1'b1;
        Req_valid = 1'b0;
        Req_op = 3'b000;
        Req_addr_lo = 2'b00;
        Req_dest = 5'd0;
        Mem_rvalid = 1'b0;
        Mem_rdata = 32'h0;
        step();
        step();
        chk("rst_addr", 32'(Rd_addr), 32'd0);
        chk("rst_data", Rd_in, 32'h0);
        chk("rst_en", 32'(Rd_write_byte_en), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_aerr", 32'(Addr_err), 32'd0);
        chk("rst_tmo", 32'(Timeout), 32'd0);
        chk("rst_memreq", 32'(Mem_req), 32'd0);
        chk("rst_ready", 32'(Req_ready), 32'd0);
        Reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(Req_ready), 32'd1);

        run_load("lb_k2", 3'b000, 2'd2, 5'd5, 32'h11223344,
                 32'h00000022, 4'b1111);
        run_load("lb_k0", 3'b000, 2'd0, 5'd6, 32'h000000F0,
                 32'hFFFFFFF0, 4'b1111);
        run_load("lbu_k0", 3'b100, 2'd0, 5'd7, 32'h000000F0,
                 32'h000000F0, 4'b1111);
        run_load("lbu_k3", 3'b100, 2'd3, 5'd8, 32'hA5000000,
                 32'h000000A5, 4'b1111);
        run_load("lhu_k2", 3'b101, 2'd2, 5'd10, 32'h80010000,
                 32'h00008001, 4'b1111);
        run_load("lh_k2", 3'b001, 2'd2, 5'd11, 32'h80010000,
                 32'hFFFF8001, 4'b1111);
        run_load("lh_k0", 3'b001, 2'd0, 5'd12, 32'h12347FFE,
                 32'h00007FFE, 4'b1111);
        run_load("lw_k0", 3'b011, 2'd0, 5'd31, 32'hDEADBEEF,
                 32'hDEADBEEF, 4'b1111);
        run_load("dest0", 3'b000, 2'd1, 5'd0, 32'h0000C300,
                 32'hFFFFFFC3, 4'b1111);

`ifdef UNALIGNED_LOAD_EN
        run_load("lwl_k1", 3'b010, 2'd1, 5'd3, 32'hAABBCCDD,
                 32'hCCDD0000, 4'b1100);
        run_load("lwr_k1", 3'b110, 2'd1, 5'd3, 32'hAABBCCDD,
                 32'h00AABBCC, 4'b0111);
        run_load("lwl_k0", 3'b010, 2'd0, 5'd3, 32'hAABBCCDD,
                 32'hDD000000, 4'b1000);
        run_load("lwl_k3", 3'b010, 2'd3, 5'd3, 32'hAABBCCDD,
                 32'hAABBCCDD, 4'b1111);
        run_load("lwr_k3", 3'b110, 2'd3, 5'd3, 32'hAABBCCDD,
                 32'h000000AA, 4'b0001);
`else
        run_illegal("lwl_dis", 3'b010, 2'd1);
        run_illegal("lwr_dis", 3'b110, 2'd0);
`endif

        run_illegal("lw_k2", 3'b011, 2'd2);
        run_illegal("lh_k1", 3'b001, 2'd1);
        run_illegal("lhu_k3", 3'b101, 2'd3);
        run_illegal("op111", 3'b111, 2'd0);

        // stray response while idle
        Mem_rvalid = 1'b1;
        Mem_rdata = 32'h55555555;
        step();
        Mem_rvalid = 1'b0;
        chk("stray_done", 32'(Done), 32'd0);
        chk("stray_en", 32'(Rd_write_byte_en), 32'd0);
        chk("stray_memreq", 32'(Mem_req), 32'd0);

        // no response for 16 cycles
        Req_valid = 1'b1;
        Req_op = 3'b000;
        Req_addr_lo = 2'd0;
        Req_dest = 5'd4;
        step();
        Req_valid = 1'b0;
        all_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            all_req = all_req & Mem_req & ~Timeout & ~Req_ready;
            step();
        end
        chk("tmo_wait_req", 32'(all_req), 32'd1);
        chk("tmo_pulse", 32'(Timeout), 32'd1);
        chk("tmo_ready", 32'(Req_ready), 32'd1);
        chk("tmo_memreq", 32'(Mem_req), 32'd0);
        chk("tmo_done", 32'(Done), 32'd0);
        chk("tmo_en", 32'(Rd_write_byte_en), 32'd0);
        step();
        chk("tmo_pulse_off", 32'(Timeout), 32'd0);

        // response in the 16th waiting cycle
        Req_valid = 1'b1;
        Req_op = 3'b100;
        Req_addr_lo = 2'd1;
        Req_dest = 5'd13;
        step();
        Req_valid = 1'b0;
        for (int i = 1; i <= 15; i++) step();
        chk("late_memreq", 32'(Mem_req), 32'd1);
        Mem_rvalid = 1'b1;
        Mem_rdata = 32'h0000BE00;
        step();
        Mem_rvalid = 1'b0;
        chk("late_done", 32'(Done), 32'd1);
        chk("late_tmo", 32'(Timeout), 32'd0);
        chk("late_data", Rd_in, 32'h000000BE);
        chk("late_addr", 32'(Rd_addr), 32'd13);
        step();
        chk("late_ready", 32'(Req_ready), 32'd1);

        // reset while waiting, then a response arrives
        Req_valid = 1'b1;
        Req_op = 3'b011;
        Req_addr_lo = 2'd0;
        Req_dest = 5'd20;
        step();
        Req_valid = 1'b0;
        chk("rw_memreq", 32'(Mem_req), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Mem_rvalid = 1'b1;
        Mem_rdata = 32'hCAFEF00D;
        #1;
        chk("rw_memreq_off", 32'(Mem_req), 32'd0);
        chk("rw_ready", 32'(Req_ready), 32'd1);
        step();
        Mem_rvalid = 1'b0;
        chk("rw_done", 32'(Done), 32'd0);
        chk("rw_en", 32'(Rd_write_byte_en), 32'd0);
        chk("rw_addr", 32'(Rd_addr), 32'd0);
        chk("rw_data", Rd_in, 32'h0);
        chk("rw_tmo", 32'(Timeout), 32'd0);
        chk("rw_ready2", 32'(Req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
